// File: rtl/window_peak_tracker.sv
// Tracks the running max/min over windows of WIN_LEN accepted samples and publishes them on
// each window close with an EN_WIDTH-cycle dat_limit_en pulse. Define PEAK_SIGNED_EN for signed samples.
module window_peak_tracker #(
    parameter int unsigned WIN_LEN  = 1024,
    parameter int unsigned EN_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dat_in,
    input  logic        dat_valid,
    input  logic        win_clr,
    output logic [15:0] dat_max,
    output logic [15:0] dat_min,
    output logic        dat_limit_en,
    output logic [15:0] win_cnt,
    output logic        state_dbg
);

    // Handshake: dat_valid qualifies dat_in for one cycle; there is no ready, so every valid
    // sample is taken on that edge unless win_clr is high in the same cycle (then it is dropped).

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(WIN_LEN - 1);
    localparam logic [7:0]  EN_LOAD  = 8'(EN_WIDTH);

`ifdef PEAK_SIGNED_EN
    // Offset binary on the outputs so an unsigned max-min downstream gives the true span.
    localparam logic [15:0] OUT_FLIP = 16'h8000;
`else
    localparam logic [15:0] OUT_FLIP = 16'h0000;
`endif

    function automatic logic above(input logic [15:0] a, input logic [15:0] b);
`ifdef PEAK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt_nx;
    logic [15:0] run_max;
    logic [15:0] run_min;
    logic [15:0] max_nx;
    logic [15:0] min_nx;
    logic        close;
    logic [7:0]  en_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            win_cnt <= '0;
            run_max <= '0;
            run_min <= '0;
        end else begin
            state   <= state_nx;
            win_cnt <= cnt_nx;
            run_max <= max_nx;
            run_min <= min_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = win_cnt;
        max_nx   = run_max;
        min_nx   = run_min;
        close    = 1'b0;
        if (win_clr) begin
            state_nx = EMPTY;
            cnt_nx   = '0;
        end else if (dat_valid) begin
            case (state)
                EMPTY: begin
                    max_nx   = dat_in;
                    min_nx   = dat_in;
                    cnt_nx   = 16'd1;
                    state_nx = ACCUM;
                end
                ACCUM: begin
                    // Strict compares: ties keep the stored extreme.
                    if (above(dat_in, run_max)) max_nx = dat_in;
                    if (above(run_min, dat_in)) min_nx = dat_in;
                    if (win_cnt == LAST_CNT) begin
                        close    = 1'b1;
                        cnt_nx   = '0;
                        state_nx = EMPTY;
                    end else begin
                        cnt_nx = win_cnt + 16'd1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dat_max <= '0;
            dat_min <= '0;
        end else if (close) begin
            dat_max <= max_nx ^ OUT_FLIP;
            dat_min <= min_nx ^ OUT_FLIP;
        end
    end

    // en_cnt holds the number of pulse cycles still to show, including the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_cnt <= '0;
        end else if (close) begin
            en_cnt <= EN_LOAD;
        end else if (en_cnt != 8'd0) begin
            en_cnt <= en_cnt - 8'd1;
        end
    end

    assign dat_limit_en = (en_cnt != 8'd0);
    assign state_dbg    = state;

endmodule

// File: tb/tb_window_peak_tracker.sv
// Scoreboarded bench for window_peak_tracker: three instances with different window/pulse sizes
// share one stimulus stream and are checked against a sample-list reference model.
`timescale 1ns/1ps
module tb_window_peak_tracker;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] dat_in = '0;
    logic        dat_valid = 1'b0;
    logic        win_clr = 1'b0;

    logic [15:0] o_max [N];
    logic [15:0] o_min [N];
    logic [15:0] o_cnt [N];
    logic        o_en  [N];
    logic        o_st  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        window_peak_tracker #(
            .WIN_LEN (g == 2 ? 2 : 4),
            .EN_WIDTH(g == 0 ? 2 : (g == 1 ? 3 : 1))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .dat_in      (dat_in),
            .dat_valid   (dat_valid),
            .win_clr     (win_clr),
            .dat_max     (o_max[g]),
            .dat_min     (o_min[g]),
            .dat_limit_en(o_en[g]),
            .win_cnt     (o_cnt[g]),
            .state_dbg   (o_st[g])
        );
    end

`ifdef PEAK_SIGNED_EN
    localparam logic [15:0] FLIP = 16'h8000;
`else
    localparam logic [15:0] FLIP = 16'h0000;
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] win_q [N][$];
    logic [31:0] exp_q [N][$];
    logic [15:0] pub_max [N];
    logic [15:0] pub_min [N];
    int          close_edge [N];
    logic        prev_en [N];

    function automatic int wl(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int enw(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
    endfunction

    function automatic bit gt(input logic [15:0] a, input logic [15:0] b);
`ifdef PEAK_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, i, act, want, $time);
        end
    endtask

    // Reference model: keep the raw samples of the open window; at a close pick the extremes.
    task automatic model_step(input logic v, input logic [15:0] d, input logic c);
        logic [15:0] mx;
        logic [15:0] mn;
        for (int i = 0; i < N; i++) begin
            if (c) begin
                win_q[i].delete();
            end else if (v) begin
                win_q[i].push_back(d);
                if (win_q[i].size() == wl(i)) begin
                    mx = win_q[i][0];
                    mn = win_q[i][0];
                    foreach (win_q[i][k]) begin
                        if (gt(win_q[i][k], mx)) mx = win_q[i][k];
                        if (gt(mn, win_q[i][k])) mn = win_q[i][k];
                    end
                    pub_max[i] = mx ^ FLIP;
                    pub_min[i] = mn ^ FLIP;
                    exp_q[i].push_back({pub_max[i], pub_min[i]});
                    win_q[i].delete();
                    close_edge[i] = cyc + 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            win_q[i].delete();
            exp_q[i].delete();
            pub_max[i] = '0;
            pub_min[i] = '0;
            close_edge[i] = -1000;
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic c);
        @(negedge clk);
        dat_valid = v;
        dat_in    = d;
        win_clr   = c;
        model_step(v, d, c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b0;
        dat_valid = 1'b0;
        win_clr   = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++) begin
            chk("async_rst_max", i, {16'h0, o_max[i]}, 32'h0);
            chk("async_rst_min", i, {16'h0, o_min[i]}, 32'h0);
            chk("async_rst_en",  i, {31'h0, o_en[i]},  32'h0);
            chk("async_rst_cnt", i, {16'h0, o_cnt[i]}, 32'h0);
        end
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: per-cycle checks of every output, plus a scoreboard pop on each pulse rising edge.
    always @(posedge clk) begin
        logic [31:0] got;
        logic        want_en;
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < N; i++) begin
            want_en = ((cyc - close_edge[i]) >= 0) && ((cyc - close_edge[i]) < enw(i));
            chk("win_cnt", i, {16'h0, o_cnt[i]}, win_q[i].size());
            chk("dat_max", i, {16'h0, o_max[i]}, {16'h0, pub_max[i]});
            chk("dat_min", i, {16'h0, o_min[i]}, {16'h0, pub_min[i]});
            chk("limit_en", i, {31'h0, o_en[i]}, {31'h0, want_en});
            if (o_en[i] && !prev_en[i]) begin
                got = {o_max[i], o_min[i]};
                if (exp_q[i].size() == 0) begin
                    chk("unexpected_pulse", i, 32'h1, 32'h0);
                end else begin
                    chk("publish", i, got, exp_q[i].pop_front());
                end
            end
            prev_en[i] = o_en[i];
        end
    end

    logic [15:0] pat [4];

    initial begin
        pat[0] = 16'h1000; pat[1] = 16'h9000; pat[2] = 16'h3000; pat[3] = 16'h5000;
        for (int i = 0; i < N; i++) prev_en[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Back-to-back window, then the same samples with idle gaps
        for (int k = 0; k < 4; k++) drive(1'b1, pat[k], 1'b0);
        idle(6);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, pat[k], 1'b0);
            idle(3);
        end
        idle(4);

        // Close, partial window, clear, then a flat window of 0x2000
        for (int k = 0; k < 4; k++) drive(1'b1, pat[k], 1'b0);
        drive(1'b1, 16'h7777, 1'b0);
        drive(1'b1, 16'h0001, 1'b0);
        drive(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h2000, 1'b0);
        idle(5);

        // Clear together with a valid sample, and with a would-be closing sample
        drive(1'b1, 16'hAAAA, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 16'h0100 + 16'(k), 1'b0);
        drive(1'b1, 16'hFFFF, 1'b1);
        idle(5);

        // Continuous valid for 12 cycles
        for (int k = 0; k < 12; k++) drive(1'b1, 16'($urandom), 1'b0);
        idle(6);

        // Reset mid-window, and reset mid-pulse
        drive(1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, pat[k], 1'b0);
        do_reset(2);
        for (int k = 0; k < 4; k++) drive(1'b1, pat[k], 1'b0);
        drive(1'b1, 16'h4444, 1'b0);
        drive(1'b1, 16'h0444, 1'b0);
        do_reset(3);
        for (int k = 0; k < 4; k++) drive(1'b1, pat[3-k], 1'b0);
        idle(5);

        // Mixed-sign pair on the 2-sample window
        drive(1'b0, 16'h0000, 1'b1);
        drive(1'b1, 16'hF000, 1'b0);
        drive(1'b1, 16'h1000, 1'b0);
        idle(4);

        // Random traffic including boundary values and ties
        for (int k = 0; k < 600; k++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0: d = 16'h0000;
                1: d = 16'hFFFF;
                2: d = 16'h8000;
                3: d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 40) == 0);
        end
        idle(8);

        for (int i = 0; i < N; i++) chk("drain", i, exp_q[i].size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
